// File: rtl/hpb_cfg_pkg.sv
// Shared types for the host config responder:
// opcodes, entry layout, word field positions and FSM states.
package hpb_cfg_pkg;

  typedef enum logic [7:0] {
    OP_WRITE     = 8'h01,
    OP_ENABLE    = 8'h02,
    OP_DISABLE   = 8'h03,
    OP_CLEAR_ALL = 8'h04
  } opcode_e;

  typedef struct packed {
    logic [63:0] symbol_id;
    logic [63:0] price_limit;
    logic [31:0] max_qty;
    logic        en;
  } strategy_entry_t;

  localparam int OP_HI  = 255;
  localparam int OP_LO  = 248;
  localparam int IDX_HI = 247;
  localparam int IDX_LO = 240;
  localparam int SYM_HI = 239;
  localparam int SYM_LO = 176;
  localparam int PRC_HI = 175;
  localparam int PRC_LO = 112;
  localparam int QTY_HI = 111;
  localparam int QTY_LO = 80;
  localparam int EN_BIT = 79;
  localparam int CMD_LO = 79;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_EXEC,
    S_CLEAR,
    S_ACK
  } state_e;

  function automatic strategy_entry_t word_entry(
    input logic [255:CMD_LO] w
  );
    strategy_entry_t e;
    e.symbol_id   = w[SYM_HI:SYM_LO];
    e.price_limit = w[PRC_HI:PRC_LO];
    e.max_qty     = w[QTY_HI:QTY_LO];
    e.en          = w[EN_BIT];
    return e;
  endfunction

endpackage

// File: rtl/hpb_cfg_table.sv
// Strategy entry register array with masked write,
// single-entry clear and a registered read port.
module hpb_cfg_table
  import hpb_cfg_pkg::*;
#(
  parameter int unsigned NUM_ENTRIES = 16,
  parameter int unsigned IDX_W = $clog2(NUM_ENTRIES)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   wr_en_i,
  input  logic [IDX_W-1:0]       wr_idx_i,
  input  strategy_entry_t        wr_mask_i,
  input  strategy_entry_t        wr_data_i,
  input  logic                   clr_en_i,
  input  logic [IDX_W-1:0]       clr_idx_i,
  input  logic [IDX_W-1:0]       rd_idx_i,
  output strategy_entry_t        rd_data_o,
  output logic [NUM_ENTRIES-1:0] entry_en_o
);

  strategy_entry_t tbl_q [NUM_ENTRIES];
  strategy_entry_t rd_q;
  logic            rd_ok;

  assign rd_ok = 32'(rd_idx_i) < 32'(NUM_ENTRIES);

  // Read samples pre-write contents, so a same-index write returns old data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_ENTRIES; i++) tbl_q[i] <= '0;
      rd_q <= '0;
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if (clr_en_i && clr_idx_i == IDX_W'(i))
          tbl_q[i] <= '0;
        else if (wr_en_i && wr_idx_i == IDX_W'(i))
          tbl_q[i] <= (tbl_q[i] & ~wr_mask_i)
                    | (wr_data_i & wr_mask_i);
      end
      rd_q <= rd_ok ? tbl_q[rd_idx_i] : '0;
    end
  end

  always_comb begin
    entry_en_o = '0;
    for (int i = 0; i < NUM_ENTRIES; i++)
      entry_en_o[i] = tbl_q[i].en;
  end

  assign rd_data_o = rd_q;

endmodule

// File: rtl/hpb_cfg_responder.sv
// Core-clock config responder: captures host words, decodes
// them into table commands and acknowledges each one once.
module hpb_cfg_responder
  import hpb_cfg_pkg::*;
#(
  parameter int unsigned NUM_ENTRIES = 16,
  parameter int unsigned IDX_W = $clog2(NUM_ENTRIES)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   in_config_valid,
  input  logic [255:0]           in_config_data,
  output logic                   in_config_accept,
  input  logic [IDX_W-1:0]       rd_idx,
  output strategy_entry_t        rd_data,
  output logic [NUM_ENTRIES-1:0] entry_en,
  output logic                   cfg_update,
  output logic [IDX_W-1:0]       cfg_update_idx,
  output logic [15:0]            err_count,
  output logic                   proto_err
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_ENTRIES - 1);

  state_e            state_q, state_d;
  logic              pend_q;
  logic [255:CMD_LO] cmd_q;
  logic [IDX_W-1:0]  clr_idx_q, clr_idx_d;
  logic [15:0]       err_q, err_d;
  logic              proto_q;
  logic              upd_q, upd_d;
  logic [IDX_W-1:0]  upd_idx_q, upd_idx_d;

  logic             busy, take;
  logic [7:0]       op, idx8;
  logic [IDX_W-1:0] idx;
  logic             idx_ok, is_wr, is_en, is_dis, is_clr;
  logic             single_ok;
  logic             tbl_we, tbl_ce;
  strategy_entry_t  wr_data, wr_mask;
  logic             unused_rsvd;

  assign unused_rsvd = ^in_config_data[CMD_LO-1:0];

  // A word waiting in cmd_q counts as busy until the FSM leaves IDLE.
  assign busy = pend_q | (state_q != S_IDLE);
  assign take = in_config_valid & ~busy;

  assign op        = cmd_q[OP_HI:OP_LO];
  assign idx8      = cmd_q[IDX_HI:IDX_LO];
  assign idx       = idx8[IDX_W-1:0];
  assign idx_ok    = 32'(idx8) < 32'(NUM_ENTRIES);
  assign is_wr     = op == OP_WRITE;
  assign is_en     = op == OP_ENABLE;
  assign is_dis    = op == OP_DISABLE;
  assign is_clr    = op == OP_CLEAR_ALL;
  assign single_ok = (is_wr | is_en | is_dis) & idx_ok;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      pend_q    <= 1'b0;
      cmd_q     <= '0;
      clr_idx_q <= '0;
      err_q     <= '0;
      proto_q   <= 1'b0;
      upd_q     <= 1'b0;
      upd_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      pend_q    <= take;
      clr_idx_q <= clr_idx_d;
      err_q     <= err_d;
      upd_q     <= upd_d;
      upd_idx_q <= upd_idx_d;
      if (take) cmd_q <= in_config_data[255:CMD_LO];
      if (in_config_valid && busy) proto_q <= 1'b1;
    end
  end

  always_comb begin
    state_d          = state_q;
    clr_idx_d        = clr_idx_q;
    err_d            = err_q;
    upd_d            = 1'b0;
    upd_idx_d        = upd_idx_q;
    tbl_we           = 1'b0;
    tbl_ce           = 1'b0;
    in_config_accept = 1'b0;
    unique case (state_q)
      S_IDLE: if (pend_q) state_d = S_DECODE;
      S_DECODE: begin
        clr_idx_d = '0;
        if (is_clr) begin
          state_d = S_CLEAR;
        end else begin
          // Rejected words still pass EXEC so every op acks alike.
          state_d = S_EXEC;
          if (!single_ok && err_q != 16'hFFFF)
            err_d = err_q + 16'd1;
        end
      end
      S_EXEC: begin
        tbl_we  = single_ok;
        upd_d   = single_ok;
        if (single_ok) upd_idx_d = idx;
        state_d = S_ACK;
      end
      S_CLEAR: begin
        tbl_ce = 1'b1;
        if (clr_idx_q == LAST) begin
          upd_d     = 1'b1;
          upd_idx_d = '0;
          state_d   = S_ACK;
        end else begin
          clr_idx_d = clr_idx_q + 1'b1;
        end
      end
      S_ACK: begin
        in_config_accept = 1'b1;
        state_d          = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_data = word_entry(cmd_q);
    wr_mask = '0;
    unique case (1'b1)
      is_wr: wr_mask = '1;
      is_en: begin
        wr_mask.en = 1'b1;
        wr_data.en = 1'b1;
      end
      is_dis: begin
        wr_mask.en = 1'b1;
        wr_data.en = 1'b0;
      end
      default: ;
    endcase
  end

  hpb_cfg_table #(
    .NUM_ENTRIES(NUM_ENTRIES),
    .IDX_W      (IDX_W)
  ) u_table (
    .clk       (clk),
    .reset_n   (reset_n),
    .wr_en_i   (tbl_we),
    .wr_idx_i  (idx),
    .wr_mask_i (wr_mask),
    .wr_data_i (wr_data),
    .clr_en_i  (tbl_ce),
    .clr_idx_i (clr_idx_q),
    .rd_idx_i  (rd_idx),
    .rd_data_o (rd_data),
    .entry_en_o(entry_en)
  );

  assign cfg_update     = upd_q;
  assign cfg_update_idx = upd_idx_q;
  assign err_count      = err_q;
  assign proto_err      = proto_q;

endmodule

// File: tb/tb_hpb_cfg_responder.sv
// Self-checking bench for hpb_cfg_responder against
// an array-based model of the strategy table.
module tb_hpb_cfg_responder;
  import hpb_cfg_pkg::*;

  localparam int NE = 16;
  localparam int IW = 4;

  logic            clk = 1'b0;
  logic            reset_n = 1'b1;
  logic            in_config_valid = 1'b0;
  logic [255:0]    in_config_data = '0;
  logic            in_config_accept;
  logic [IW-1:0]   rd_idx = '0;
  strategy_entry_t rd_data;
  logic [NE-1:0]   entry_en;
  logic            cfg_update;
  logic [IW-1:0]   cfg_update_idx;
  logic [15:0]     err_count;
  logic            proto_err;

  int checks = 0;
  int errors = 0;

  strategy_entry_t m_tbl [NE];
  int m_err = 0;
  bit m_proto = 0;

  always #5 clk = ~clk;

  hpb_cfg_responder #(.NUM_ENTRIES(NE), .IDX_W(IW)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .in_config_valid (in_config_valid),
    .in_config_data  (in_config_data),
    .in_config_accept(in_config_accept),
    .rd_idx          (rd_idx),
    .rd_data         (rd_data),
    .entry_en        (entry_en),
    .cfg_update      (cfg_update),
    .cfg_update_idx  (cfg_update_idx),
    .err_count       (err_count),
    .proto_err       (proto_err)
  );

  function automatic logic [255:0] mk(input logic [7:0] op,
    input logic [7:0] idx, input logic [63:0] sym,
    input logic [63:0] prc, input logic [31:0] qty, input logic en);
    logic [14:0] r0;
    logic [63:0] r1;
    r0 = 15'($urandom);
    r1 = {$urandom, $urandom};
    return {op, idx, sym, prc, qty, en, r0, r1};
  endfunction

  function automatic logic [NE-1:0] model_en();
    logic [NE-1:0] v;
    for (int i = 0; i < NE; i++) v[i] = m_tbl[i].en;
    return v;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NE; i++) m_tbl[i] = '0;
    m_err = 0;
    m_proto = 0;
  endfunction

  function automatic void model_apply(input logic [255:0] w,
    output int lat, output int upd, output int uidx);
    int op;
    int idx;
    op = int'(w[255:248]);
    idx = int'(w[247:240]);
    lat = (op == 4) ? 2 + NE : 3;
    upd = 0;
    uidx = 0;
    if (op == 4) begin
      for (int i = 0; i < NE; i++) m_tbl[i] = '0;
      upd = 1;
    end else if (op >= 1 && op <= 3 && idx < NE) begin
      upd = 1;
      uidx = idx;
      if (op == 1) m_tbl[idx] = {w[239:176], w[175:112], w[111:80], w[79]};
      else m_tbl[idx].en = (op == 2);
    end else if (m_err < 65535) begin
      m_err++;
    end
  endfunction

  // Drives one word, watches until the accept, returns in the IDLE cycle.
  task automatic issue(input logic [255:0] w, output int acc_lat,
    output int n_acc, output int upd_lat, output int n_upd,
    output int upd_idx, output logic [NE-1:0] en_at_upd);
    acc_lat = -1; n_acc = 0; upd_lat = -1; n_upd = 0;
    upd_idx = -1; en_at_upd = '0;
    in_config_valid = 1'b1;
    in_config_data = w;
    @(negedge clk);
    in_config_valid = 1'b0;
    in_config_data = {8{$urandom}};
    for (int k = 1; k <= NE + 10 && acc_lat < 0; k++) begin
      @(negedge clk);
      if (cfg_update) begin
        n_upd++; upd_lat = k;
        upd_idx = int'(cfg_update_idx); en_at_upd = entry_en;
      end
      if (in_config_accept) begin n_acc++; acc_lat = k; end
    end
    @(negedge clk);
    if (in_config_accept) n_acc++;
    if (cfg_update) n_upd++;
  endtask

  task automatic test_reset();
    #1 reset_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    checks++; if ({in_config_accept, cfg_update, proto_err} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {in_config_accept, cfg_update, proto_err}); end
    checks++; if (rd_data !== '0) begin errors++; $display("FAIL reset_rd: got %h want 0", rd_data); end
    checks++; if (entry_en !== '0 || err_count !== 16'd0 || cfg_update_idx !== '0) begin errors++; $display("FAIL reset_regs: en %h err %h idx %h want 0", entry_en, err_count, cfg_update_idx); end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write();
    int al, na, ul, nu, ui, el, eu, ei;
    logic [NE-1:0] ea;
    strategy_entry_t exp_e;
    logic [255:0] w;
    w = mk(8'h01, 8'd3, 64'hABCD, 64'd100, 32'd50, 1'b1);
    exp_e = {64'hABCD, 64'd100, 32'd50, 1'b1};
    model_apply(w, el, eu, ei);
    issue(w, al, na, ul, nu, ui, ea);
    checks++; if (al !== 3 || na !== 1) begin errors++; $display("FAIL wr_accept: lat %0d n %0d want 3 1", al, na); end
    checks++; if (ul !== 3 || nu !== 1 || ui !== 3) begin errors++; $display("FAIL wr_update: lat %0d n %0d idx %0d want 3 1 3", ul, nu, ui); end
    checks++; if (ea !== model_en() || ea[3] !== 1'b1) begin errors++; $display("FAIL wr_en_at_update: got %h want %h", ea, model_en()); end
    rd_idx = 4'd3;
    @(negedge clk);
    checks++; if (rd_data !== exp_e) begin errors++; $display("FAIL wr_rd: got %h want %h", rd_data, exp_e); end
  endtask

  task automatic test_disable();
    int al, na, ul, nu, ui, el, eu, ei;
    logic [NE-1:0] ea;
    logic [255:0] w;
    w = mk(8'h03, 8'd3, {$urandom, $urandom}, 64'd7, 32'd9, 1'b1);
    model_apply(w, el, eu, ei);
    issue(w, al, na, ul, nu, ui, ea);
    rd_idx = 4'd3;
    @(negedge clk);
    checks++; if (entry_en[3] !== 1'b0 || al !== 3) begin errors++; $display("FAIL dis_en: en %b lat %0d want 0 3", entry_en[3], al); end
    checks++; if (rd_data !== m_tbl[3] || rd_data.symbol_id !== 64'hABCD) begin errors++; $display("FAIL dis_fields: got %h want %h", rd_data, m_tbl[3]); end
    checks++; if (err_count !== 16'd0) begin errors++; $display("FAIL dis_err: got %0d want 0", err_count); end
  endtask

  task automatic test_errors();
    int al, na, ul, nu, ui, el, eu, ei;
    logic [NE-1:0] ea;
    logic [255:0] w;
    w = mk(8'h7F, 8'd2, 64'd1, 64'd2, 32'd3, 1'b1);
    model_apply(w, el, eu, ei);
    issue(w, al, na, ul, nu, ui, ea);
    checks++; if (al !== 3 || na !== 1 || nu !== 0) begin errors++; $display("FAIL err_op: lat %0d n %0d upd %0d want 3 1 0", al, na, nu); end
    w = mk(8'h01, 8'd16, 64'd5, 64'd6, 32'd7, 1'b1);
    model_apply(w, el, eu, ei);
    issue(w, al, na, ul, nu, ui, ea);
    checks++; if (al !== 3 || na !== 1 || nu !== 0) begin errors++; $display("FAIL err_idx: lat %0d n %0d upd %0d want 3 1 0", al, na, nu); end
    checks++; if (err_count !== 16'd2 || entry_en !== model_en()) begin errors++; $display("FAIL err_count: cnt %0d en %h want 2 %h", err_count, entry_en, model_en()); end
  endtask

  task automatic test_random();
    int al, na, ul, nu, ui, el, eu, ei, r, ri;
    logic [NE-1:0] ea;
    logic [7:0] op;
    logic [255:0] w;
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      if (r < 4) op = 8'h01;
      else if (r < 6) op = 8'h02;
      else if (r < 8) op = 8'h03;
      else if (r == 8) op = 8'(5 + $urandom_range(0, 250));
      else op = 8'h04;
      w = mk(op, 8'($urandom_range(0, 19)), {$urandom, $urandom},
             {$urandom, $urandom}, $urandom, 1'($urandom));
      model_apply(w, el, eu, ei);
      issue(w, al, na, ul, nu, ui, ea);
      checks++; if (al !== el || na !== 1) begin errors++; $display("FAIL rnd_accept op %h: lat %0d n %0d want %0d 1", op, al, na, el); end
      checks++; if (nu !== eu || (eu == 1 && (ui !== ei || ul !== el))) begin errors++; $display("FAIL rnd_update op %h: n %0d idx %0d lat %0d want %0d %0d %0d", op, nu, ui, ul, eu, ei, el); end
      checks++; if (entry_en !== model_en() || err_count !== 16'(m_err)) begin errors++; $display("FAIL rnd_state: en %h err %0d want %h %0d", entry_en, err_count, model_en(), m_err); end
      ri = $urandom_range(0, NE - 1);
      rd_idx = IW'(ri);
      @(negedge clk);
      checks++; if (rd_data !== m_tbl[ri]) begin errors++; $display("FAIL rnd_rd idx %0d: got %h want %h", ri, rd_data, m_tbl[ri]); end
    end
  endtask

  task automatic test_back_to_back();
    int al, na, ul, nu, ui, el, eu, ei;
    logic [NE-1:0] ea;
    logic [255:0] w;
    for (int n = 0; n < 3; n++) begin
      w = mk(8'h01, 8'(10 + n), {$urandom, $urandom}, 64'(n), 32'(n), 1'b1);
      model_apply(w, el, eu, ei);
      issue(w, al, na, ul, nu, ui, ea);
      checks++; if (al !== 3 || na !== 1 || ui !== 10 + n) begin errors++; $display("FAIL b2b_accept %0d: lat %0d n %0d idx %0d", n, al, na, ui); end
    end
    checks++; if (proto_err !== 1'b0 || entry_en !== model_en()) begin errors++; $display("FAIL b2b_state: proto %b en %h want 0 %h", proto_err, entry_en, model_en()); end
  endtask

  task automatic test_clear();
    int al, na, ul, nu, ui, el, eu, ei;
    int bad;
    logic [NE-1:0] ea;
    logic [255:0] w;
    for (int i = 0; i < NE; i++) begin
      w = mk(8'h01, 8'(i), {$urandom, $urandom}, {$urandom, $urandom}, $urandom, 1'b1);
      model_apply(w, el, eu, ei);
      issue(w, al, na, ul, nu, ui, ea);
    end
    checks++; if (entry_en !== {NE{1'b1}}) begin errors++; $display("FAIL clr_fill: got %h want all ones", entry_en); end
    w = mk(8'h04, 8'd9, 64'd1, 64'd1, 32'd1, 1'b1);
    model_apply(w, el, eu, ei);
    issue(w, al, na, ul, nu, ui, ea);
    checks++; if (al !== 2 + NE || na !== 1) begin errors++; $display("FAIL clr_accept: lat %0d n %0d want %0d 1", al, na, 2 + NE); end
    checks++; if (ul !== 2 + NE || nu !== 1 || ui !== 0) begin errors++; $display("FAIL clr_update: lat %0d n %0d idx %0d want %0d 1 0", ul, nu, ui, 2 + NE); end
    checks++; if (entry_en !== '0) begin errors++; $display("FAIL clr_en: got %h want 0", entry_en); end
    bad = 0;
    for (int i = 0; i < NE; i++) begin
      rd_idx = IW'(i);
      @(negedge clk);
      if (rd_data !== '0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL clr_rd: %0d nonzero entries want 0", bad); end
  endtask

  task automatic test_ack_valid();
    int na, el, eu, ei, seen;
    logic [255:0] w;
    w = mk(8'h01, 8'd1, 64'h11, 64'h22, 32'h33, 1'b1);
    model_apply(w, el, eu, ei);
    in_config_valid = 1'b1;
    in_config_data = w;
    @(negedge clk);
    in_config_valid = 1'b0;
    seen = 0;
    for (int k = 1; k <= 10 && seen == 0; k++) begin
      @(negedge clk);
      if (in_config_accept) seen = k;
    end
    in_config_valid = 1'b1;
    in_config_data = mk(8'h01, 8'd2, 64'h44, 64'h55, 32'h66, 1'b1);
    @(negedge clk);
    in_config_valid = 1'b0;
    m_proto = 1;
    na = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (in_config_accept) na++;
    end
    checks++; if (seen !== 3 || proto_err !== 1'b1) begin errors++; $display("FAIL ack_valid_proto: lat %0d proto %b want 3 1", seen, proto_err); end
    checks++; if (na !== 0 || entry_en !== model_en()) begin errors++; $display("FAIL ack_valid_drop: acc %0d en %h want 0 %h", na, entry_en, model_en()); end
  endtask

  task automatic test_reset_mid_clear();
    int al, na, ul, nu, ui, el, eu, ei;
    logic [NE-1:0] ea;
    logic [255:0] w;
    for (int i = 4; i < 8; i++) begin
      w = mk(8'h01, 8'(i), {$urandom, $urandom}, 64'd1, 32'd1, 1'b1);
      model_apply(w, el, eu, ei);
      issue(w, al, na, ul, nu, ui, ea);
    end
    in_config_valid = 1'b1;
    in_config_data = mk(8'h04, 8'd0, 64'd0, 64'd0, 32'd0, 1'b0);
    @(negedge clk);
    in_config_valid = 1'b0;
    repeat (5) @(negedge clk);
    rd_idx = 4'd6;
    reset_n = 1'b0;
    model_reset();
    #1;
    checks++; if ({in_config_accept, cfg_update, proto_err} !== 3'b000 || cfg_update_idx !== '0) begin errors++; $display("FAIL rst_mid_flags: got %b idx %0d want 000 0", {in_config_accept, cfg_update, proto_err}, cfg_update_idx); end
    checks++; if (entry_en !== '0 || rd_data !== '0 || err_count !== 16'd0) begin errors++; $display("FAIL rst_mid_regs: en %h rd %h err %0d want 0", entry_en, rd_data, err_count); end
    na = 0;
    repeat (2) begin @(negedge clk); if (in_config_accept) na++; end
    reset_n = 1'b1;
    repeat (NE + 4) begin @(negedge clk); if (in_config_accept) na++; end
    checks++; if (na !== 0) begin errors++; $display("FAIL rst_mid_noack: got %0d accepts want 0", na); end
    w = mk(8'h01, 8'd12, 64'hBEEF, 64'd8, 32'd4, 1'b1);
    model_apply(w, el, eu, ei);
    issue(w, al, na, ul, nu, ui, ea);
    checks++; if (al !== 3 || na !== 1 || entry_en !== model_en()) begin errors++; $display("FAIL rst_mid_write: lat %0d n %0d en %h want 3 1 %h", al, na, entry_en, model_en()); end
  endtask

  task automatic test_proto();
    int na, al, el, eu, ei;
    logic [255:0] w;
    w = mk(8'h01, 8'd5, 64'h55, 64'h66, 32'h77, 1'b1);
    model_apply(w, el, eu, ei);
    in_config_valid = 1'b1;
    in_config_data = w;
    @(negedge clk);
    in_config_data = mk(8'h01, 8'd6, 64'h88, 64'h99, 32'hAA, 1'b1);
    @(negedge clk);
    in_config_valid = 1'b0;
    na = 0; al = -1;
    for (int k = 2; k <= 12; k++) begin
      @(negedge clk);
      if (in_config_accept) begin na++; al = k; end
    end
    checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL proto_flag: got %b want 1", proto_err); end
    checks++; if (na !== 1 || al !== 3) begin errors++; $display("FAIL proto_accept: n %0d lat %0d want 1 3", na, al); end
    rd_idx = 4'd5;
    @(negedge clk);
    checks++; if (entry_en !== model_en() || rd_data !== m_tbl[5]) begin errors++; $display("FAIL proto_exec: en %h rd %h want %h %h", entry_en, rd_data, model_en(), m_tbl[5]); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_write();
    test_disable();
    test_errors();
    test_random();
    test_back_to_back();
    test_clear();
    test_ack_valid();
    test_reset_mid_clear();
    test_proto();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
